ecall_io_sequencer: RTL and testbench
=====================================

// Module: ecall_io_sequencer
// PURPOSE
//  Sequences environment-call I/O around the memory/IO data path: stalls the pipeline while an ecall is serviced.
//  READ_INT waits for a fresh confirm-button press, then returns zero-extended switch data for register write-back.
//  PRINT_INT strobes a0 into the LED/seven-segment display path and holds the pipeline for a fixed display time.
//  Sits beside the load/store IO mux in the MEM stage; its outputs feed the write-back mux and the display write strobe.
// PARAMETERS
//  DATA_W         32    datapath width
//  SW_W           12    switch input width
//  OP_W           3     ecall operation code width
//  EOP_READ_INT   3'd1  opcode: read integer from switches
//  EOP_PRINT_INT  3'd2  opcode: print a0 to display
//  DISP_HOLD      1000  PRINT_INT stall length in cycles; 0 is treated as 1
//  CNT_W          16    hold counter width; must satisfy DISP_HOLD < 2**CNT_W
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  ecall_valid  in   1       ecall instruction present in MEM stage
//  ecall_op     in   OP_W    ecall operation code
//  a0_data      in   DATA_W  forwarded value of register a0
//  switch_data  in   SW_W    switch inputs, already synchronised
//  conf_btn     in   1       debounced confirm button level, 1 = pressed
//  stall        out  1       freeze IF..MEM; combinational
//  done         out  1       one-cycle pulse when the ecall retires
//  rd_we        out  1       write-back enable for the READ_INT result
//  rd_wdata     out  DATA_W  READ_INT result = {0, switch_data}
//  disp_we      out  1       one-cycle display write strobe
//  disp_data    out  DATA_W  value presented to LED/seg registers
// BEHAVIOUR
//  Reset
//   - rst sampled on clk: state=IDLE, cnt=0; stall/done/rd_we/disp_we=0; rd_wdata=0; disp_data=0.
//   - Reset mid-operation aborts the ecall; no done pulse; disp_data cleared.
//  States
//   - IDLE: op==READ_INT -> WAIT_REL. op==PRINT_INT -> HOLD, disp_data<=a0_data, cnt<=max(DISP_HOLD,1)-1.
//     Other op, or ecall_valid=0 -> stay in IDLE; no stall, no side effects.
//   - WAIT_REL: conf_btn==0 -> WAIT_PRESS, else stay. A button already held at ecall entry is never accepted.
//   - WAIT_PRESS: conf_btn==1 -> DONE with rd_wdata<={(DATA_W-SW_W)'b0, switch_data}, latched on that edge.
//   - HOLD: cnt==0 -> DONE, else cnt<=cnt-1.
//   - DONE: done=1; rd_we=1 only when entered from WAIT_PRESS; next state unconditionally IDLE.
//  stall (combinational) = (IDLE & ecall_valid & op known) | WAIT_REL | WAIT_PRESS | HOLD.
//   - stall is low in DONE, so the pipeline advances at the DONE->IDLE edge.
//   - ecall_op is sampled only in IDLE; changes while busy are ignored.
//  Registered strobes
//   - disp_we=1 for exactly the first cycle of HOLD; disp_data then holds until the next PRINT_INT or reset.
//   - rd_wdata holds after DONE until the next READ_INT completes.
//  Latency
//   - PRINT_INT: stall high max(DISP_HOLD,1)+1 cycles (IDLE cycle + HOLD); done in the following cycle.
//   - READ_INT: unbounded; done one cycle after the press is sampled in WAIT_PRESS.
//  Back-to-back: a new ecall_valid seen in IDLE right after DONE starts immediately; no idle gap is required.
//  Width: switch_data zero-extended; a0_data passed unmodified. Counter never wraps, since the load is < 2**CNT_W.
// TESTING
//  T1 rst high 3 cycles mid-HOLD -> all outputs 0, state IDLE, no done pulse after release.
//  T2 PRINT_INT, a0=0x0000_1234, DISP_HOLD=4 -> disp_we pulse 1 cycle; disp_data=0x1234; stall 5 cycles; done 1 cycle.
//  T3 READ_INT, conf_btn low, switch=12'hABC, press after 10 cycles -> rd_we+done 1 cycle; rd_wdata=0x0000_0ABC.
//  T4 READ_INT with conf_btn already high -> stays stalled until release, then press, then done.
//  T5 unknown op=3'd7 with ecall_valid -> stall=0, done=0, no strobes.
//  T6 PRINT_INT DONE followed by READ_INT next cycle -> READ_INT stall asserted in the first IDLE cycle.

Source files
------------

// File: rtl/ecall_io_sequencer.sv
// ecall_io_sequencer: stalls the pipeline while an environment call is serviced.
// READ_INT returns switch data on a fresh button press; PRINT_INT drives the display.
module ecall_io_sequencer #(
  parameter int              DATA_W        = 32,
  parameter int              SW_W          = 12,
  parameter int              OP_W          = 3,
  parameter logic [OP_W-1:0] EOP_READ_INT  = OP_W'(1),
  parameter logic [OP_W-1:0] EOP_PRINT_INT = OP_W'(2),
  parameter int              DISP_HOLD     = 1000,
  parameter int              CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ecall_valid,
  input  logic [OP_W-1:0]   ecall_op,
  input  logic [DATA_W-1:0] a0_data,
  input  logic [SW_W-1:0]   switch_data,
  input  logic              conf_btn,
  output logic              stall,
  output logic              done,
  output logic              rd_we,
  output logic [DATA_W-1:0] rd_wdata,
  output logic              disp_we,
  output logic [DATA_W-1:0] disp_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REL,
    S_WAIT_PRESS,
    S_HOLD,
    S_DONE
  } state_t;

  // A zero hold time still spends one cycle in HOLD.
  localparam int HOLD_N = (DISP_HOLD < 1) ? 1 : DISP_HOLD;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_N - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_read;
  logic             is_print;

  assign is_read  = (ecall_op == EOP_READ_INT);
  assign is_print = (ecall_op == EOP_PRINT_INT);

  // Stall while busy; released in DONE so the pipeline advances on exit.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      S_IDLE:       stall = ecall_valid & (is_read | is_print);
      S_WAIT_REL,
      S_WAIT_PRESS,
      S_HOLD:       stall = 1'b1;
      default:      stall = 1'b0;
    endcase
  end

  // Sequencer FSM with registered strobes and latched result data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      rd_we     <= 1'b0;
      disp_we   <= 1'b0;
      rd_wdata  <= '0;
      disp_data <= '0;
    end else begin
      done    <= 1'b0;
      rd_we   <= 1'b0;
      disp_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ecall_valid && is_read) begin
            state <= S_WAIT_REL;
          end else if (ecall_valid && is_print) begin
            state     <= S_HOLD;
            cnt       <= CNT_LOAD;
            disp_we   <= 1'b1;
            disp_data <= a0_data;
          end
        end
        S_WAIT_REL: begin
          // A button already held at entry must be released first.
          if (!conf_btn) state <= S_WAIT_PRESS;
        end
        S_WAIT_PRESS: begin
          if (conf_btn) begin
            state    <= S_DONE;
            done     <= 1'b1;
            rd_we    <= 1'b1;
            rd_wdata <= {{(DATA_W-SW_W){1'b0}}, switch_data};
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecall_io_sequencer.sv
// tb_ecall_io_sequencer: scenario tasks with a scoreboard of expected
// completions, checked when the sequencer pulses done.
module tb_ecall_io_sequencer;

  localparam int DW = 32;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ecall_valid = 1'b0;
  logic [2:0]    ecall_op = 3'd0;
  logic [DW-1:0] a0_data = '0;
  logic [SW-1:0] switch_data = '0;
  logic          conf_btn = 1'b0;
  logic          stall;
  logic          done;
  logic          rd_we;
  logic [DW-1:0] rd_wdata;
  logic          disp_we;
  logic [DW-1:0] disp_data;

  typedef struct {
    logic          we;
    logic [DW-1:0] rd;
    logic [DW-1:0] disp;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] m_rd = '0;
  logic [DW-1:0] m_disp = '0;

  always #5 clk = ~clk;

  ecall_io_sequencer #(.DISP_HOLD(4)) dut (
    .clk(clk),
    .rst(rst),
    .ecall_valid(ecall_valid),
    .ecall_op(ecall_op),
    .a0_data(a0_data),
    .switch_data(switch_data),
    .conf_btn(conf_btn),
    .stall(stall),
    .done(done),
    .rd_we(rd_we),
    .rd_wdata(rd_wdata),
    .disp_we(disp_we),
    .disp_data(disp_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({stall, done, rd_we, disp_we} !== 4'b0 ||
        rd_wdata !== '0 || disp_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got s%b d%b w%b dw%b rd=%h disp=%h want all 0",
               stall, done, rd_we, disp_we, rd_wdata, disp_data);
    end
    rst = 1'b0;
    m_rd = '0;
    m_disp = '0;
  endtask

  task automatic test_print(input logic [DW-1:0] a0);
    int sn = 0;
    int wn = 0;
    bit got = 0;
    ecall_valid = 1'b1;
    ecall_op = 3'd2;
    a0_data = a0;
    m_disp = a0;
    sb.push_back('{we: 1'b0, rd: m_rd, disp: a0});
    for (int i = 0; i < 50 && !got; i++) begin
      if (stall) sn++;
      if (disp_we) begin
        wn++;
        checks++;
        if (disp_data !== a0) begin
          errors++;
          $display("FAIL print_disp_data: got %h want %h", disp_data, a0);
        end
      end
      if (done) begin
        got = 1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL print_sb: done with empty scoreboard");
        end else begin
          e = sb.pop_front();
          if (rd_we !== e.we || rd_wdata !== e.rd || disp_data !== e.disp) begin
            errors++;
            $display("FAIL print_done: got we%b rd=%h disp=%h want we%b rd=%h disp=%h",
                     rd_we, rd_wdata, disp_data, e.we, e.rd, e.disp);
          end
        end
      end else begin
        cyc();
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL print_timeout: got no done want done");
    end
    checks++;
    if (sn != 5 || wn != 1) begin
      errors++;
      $display("FAIL print_timing: got stall=%0d we=%0d want stall=5 we=1", sn, wn);
    end
    ecall_valid = 1'b0;
    cyc();
    checks++;
    if (done !== 1'b0 || stall !== 1'b0 || disp_data !== a0) begin
      errors++;
      $display("FAIL print_after: got done%b stall%b disp=%h want 0 0 %h",
               done, stall, disp_data, a0);
    end
  endtask

  task automatic test_read(input logic [SW-1:0] sw, input bit held, input int dly);
    bit got = 0;
    conf_btn = held;
    switch_data = sw;
    ecall_valid = 1'b1;
    ecall_op = 3'd1;
    m_rd = {20'h0, sw};
    sb.push_back('{we: 1'b1, rd: m_rd, disp: m_disp});
    for (int i = 0; i < dly; i++) begin
      checks++;
      if (stall !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL read_wait[%0d]: got stall%b done%b want 1 0", i, stall, done);
      end
      cyc();
    end
    if (held) begin
      conf_btn = 1'b0;
      repeat (3) cyc();
      checks++;
      if (stall !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL read_release: got stall%b done%b want 1 0", stall, done);
      end
    end
    conf_btn = 1'b1;
    cyc();
    switch_data = ~sw;
    for (int i = 0; i < 5 && !got; i++) begin
      if (done) begin
        got = 1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL read_sb: done with empty scoreboard");
        end else begin
          e = sb.pop_front();
          if (rd_we !== e.we || rd_wdata !== e.rd || disp_data !== e.disp ||
              stall !== 1'b0) begin
            errors++;
            $display("FAIL read_done: got we%b rd=%h disp=%h st%b want we%b rd=%h disp=%h st0",
                     rd_we, rd_wdata, disp_data, stall, e.we, e.rd, e.disp);
          end
        end
      end else begin
        cyc();
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL read_timeout: got no done want done");
    end
    ecall_valid = 1'b0;
    conf_btn = 1'b0;
    cyc();
    checks++;
    if (done !== 1'b0 || rd_we !== 1'b0 || rd_wdata !== m_rd) begin
      errors++;
      $display("FAIL read_after: got done%b we%b rd=%h want 0 0 %h",
               done, rd_we, rd_wdata, m_rd);
    end
  endtask

  task automatic test_unknown_op();
    logic [2:0] ops[2];
    ops[0] = 3'd7;
    ops[1] = 3'd0;
    ecall_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ecall_op = ops[k];
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({stall, done, rd_we, disp_we} !== 4'b0) begin
          errors++;
          $display("FAIL unknown_op%0d: got s%b d%b w%b dw%b want 0000",
                   ops[k], stall, done, rd_we, disp_we);
        end
        cyc();
      end
    end
    ecall_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit got = 0;
    ecall_valid = 1'b1;
    ecall_op = 3'd2;
    a0_data = 32'hDEAD_BEEF;
    m_disp = 32'hDEAD_BEEF;
    sb.push_back('{we: 1'b0, rd: m_rd, disp: m_disp});
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1;
      else cyc();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_timeout: got no done want done");
    end else begin
      e = sb.pop_front();
      if (disp_data !== e.disp || rd_we !== e.we) begin
        errors++;
        $display("FAIL b2b_print: got disp=%h we%b want %h %b",
                 disp_data, rd_we, e.disp, e.we);
      end
    end
    ecall_op = 3'd1;
    switch_data = 12'h5A5;
    conf_btn = 1'b0;
    cyc();
    checks++;
    if (stall !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_idle: got stall%b done%b want 1 0", stall, done);
    end
    test_read(12'h5A5, 1'b0, 2);
  endtask

  task automatic test_reset_mid_hold();
    ecall_valid = 1'b1;
    ecall_op = 3'd2;
    a0_data = 32'h0BAD_F00D;
    repeat (3) cyc();
    ecall_valid = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({stall, done, rd_we, disp_we} !== 4'b0 ||
        rd_wdata !== '0 || disp_data !== '0) begin
      errors++;
      $display("FAIL midhold_reset: got s%b d%b w%b dw%b rd=%h disp=%h want all 0",
               stall, done, rd_we, disp_we, rd_wdata, disp_data);
    end
    rst = 1'b0;
    m_rd = '0;
    m_disp = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (done !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL midhold_after[%0d]: got done%b stall%b want 0 0", i, done, stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_print(32'h0000_1234);
    test_read(12'hABC, 1'b0, 10);
    test_read(12'h3C7, 1'b1, 8);
    test_unknown_op();
    test_back_to_back();
    test_print(32'hFFFF_0001);
    test_reset_mid_hold();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
